eq2_sweep_checker_amisha: RTL

Sequential stimulus generator and response checker for the 2-bit equality comparator family (eq2_sop_amisha and variants). On a start pulse it sweeps every (a, b) operand pair into the comparator under test. After a settle delay it samples the comparator's aeqb output and checks it against the expected value a==b. It counts mismatches and reports pass/fail plus the first failing vector. It sits at the driving end of the comparator interface, so comparators can be verified in hardware without a simulator testbench.

---
 rtl/eq2_sweep_checker_amisha.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/eq2_sweep_checker_amisha.sv
// ============================================================================
// Module   : eq2_sweep_checker_amisha
// Brief    : Exhaustive (a, b) sweep generator and aeqb response checker for
//            N-bit equality comparators; reports pass/fail and first failure.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eq2_sweep_checker_amisha #(
  parameter int N             = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic           clk_amisha,
  input  logic           reset_n_amisha,
  input  logic           start_amisha,
  input  logic           aeqb_amisha,
  output logic [N-1:0]   a_amisha,
  output logic [N-1:0]   b_amisha,
  output logic           busy_amisha,
  output logic           done_amisha,
  output logic           pass_amisha,
  output logic [2*N:0]   err_count_amisha,
  output logic           fail_valid_amisha,
  output logic [N-1:0]   fail_a_amisha,
  output logic [N-1:0]   fail_b_amisha
);

  localparam int         c_idx_w       = 2 * N;
  localparam bit         c_no_settle   = (SETTLE_CYCLES == 0);
  localparam logic [3:0] c_settle_last = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_idx_w-1:0]   r_idx;
  logic [3:0]           r_settle_cnt;
  logic                 r_busy;
  logic                 r_pass;
  logic [2*N:0]         r_err_count;
  logic                 r_fail_valid;
  logic [N-1:0]         r_fail_a;
  logic [N-1:0]         r_fail_b;

  logic                 w_idx_last;
  logic                 w_settle_end;
  logic                 w_mismatch;

  assign w_idx_last   = &r_idx;
  assign w_settle_end = (r_settle_cnt == c_settle_last);
  // Operands come straight from the index, so they stay stable until it moves.
  assign w_mismatch   = (aeqb_amisha != (r_idx[c_idx_w-1:N] == r_idx[N-1:0]));

  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_amisha) begin
          if (c_no_settle) w_state_next = ST_CHECK;
          else             w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_settle_end) w_state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_idx_last)       w_state_next = ST_DONE;
        else if (c_no_settle) w_state_next = ST_CHECK;
        else                  w_state_next = ST_WAIT;
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      r_idx        <= '0;
      r_settle_cnt <= 4'd0;
      r_busy       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_count  <= '0;
      r_fail_valid <= 1'b0;
      r_fail_a     <= '0;
      r_fail_b     <= '0;
    end else begin
      if (r_state == ST_WAIT) r_settle_cnt <= r_settle_cnt + 4'd1;
      else                    r_settle_cnt <= 4'd0;

      case (r_state)
        ST_IDLE: begin
          if (start_amisha) begin
            r_idx        <= '0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_pass       <= 1'b0;
            r_busy       <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (w_mismatch) begin
            r_err_count <= r_err_count + 1'b1;
            if (!r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_fail_a     <= r_idx[c_idx_w-1:N];
              r_fail_b     <= r_idx[N-1:0];
            end
          end
          // The final vector is left on the operands after the sweep.
          if (w_idx_last) r_busy <= 1'b0;
          else            r_idx  <= r_idx + 1'b1;
        end
        ST_DONE: begin
          r_pass <= (r_err_count == '0);
        end
        default: begin
        end
      endcase
    end
  end

  assign a_amisha          = r_idx[c_idx_w-1:N];
  assign b_amisha          = r_idx[N-1:0];
  assign busy_amisha       = r_busy;
  assign done_amisha       = (r_state == ST_DONE);
  assign pass_amisha       = r_pass;
  assign err_count_amisha  = r_err_count;
  assign fail_valid_amisha = r_fail_valid;
  assign fail_a_amisha     = r_fail_a;
  assign fail_b_amisha     = r_fail_b;

endmodule

`default_nettype wire
